// File: rtl/pll_seq_pkg.sv
// Shared types, default timing constants and helpers for the PLL reset sequencer.
package pll_seq_pkg;

  // Defaults sized for a 50 MHz reference clock.
  localparam int unsigned DEF_RST_HOLD_CYCLES     = 500;    // 10 us
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 50000;  // 1 ms
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_MAX_RETRIES         = 3;

  typedef enum logic [2:0] {
    StResetPll,
    StWaitLock,
    StStable,
    StRun,
    StFail
  } seq_state_e;

  typedef struct packed {
    logic pll_rst;
    logic sys_rst;
    logic ready;
    logic fail;
  } seq_out_t;

  // Width of the shared cycle counter: must hold the largest terminal count (max - 1).
  function automatic int unsigned cnt_width(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  // Output levels owned by each state; registered together with the state.
  function automatic seq_out_t state_outs(seq_state_e s);
    seq_out_t o;
    o = '{pll_rst: 1'b1, sys_rst: 1'b1, ready: 1'b0, fail: 1'b0};
    case (s)
      StResetPll: o = '{pll_rst: 1'b1, sys_rst: 1'b1, ready: 1'b0, fail: 1'b0};
      StWaitLock: o = '{pll_rst: 1'b0, sys_rst: 1'b1, ready: 1'b0, fail: 1'b0};
      StStable:   o = '{pll_rst: 1'b0, sys_rst: 1'b1, ready: 1'b0, fail: 1'b0};
      StRun:      o = '{pll_rst: 1'b0, sys_rst: 1'b0, ready: 1'b1, fail: 1'b0};
      StFail:     o = '{pll_rst: 1'b1, sys_rst: 1'b1, ready: 1'b0, fail: 1'b1};
      default:    o = '{pll_rst: 1'b1, sys_rst: 1'b1, ready: 1'b0, fail: 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the local clock domain.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Shift the async input through two flops; synchronous reset clears both.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses the PLL reset, qualifies lock, releases the
// system reset, and retries or gives up on repeated lock timeouts.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic                               refclk,
  input  logic                               rst,
  input  logic                               pll_locked,
  input  logic                               reinit_req,
  output logic                               pll_rst,
  output logic                               sys_rst,
  output logic                               ready,
  output logic                               fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
  output logic [7:0]                         loss_cnt
);

  localparam int unsigned CW = cnt_width(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES,
                                         LOCK_STABLE_CYCLES);
  localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

  logic          w_locked_s;
  seq_state_e    r_state;
  logic [CW-1:0] r_cnt;
  seq_out_t      r_outs;
  logic [RW-1:0] r_retry;
  logic [7:0]    r_loss;

  sync_2ff u_sync (
    .i_clk (refclk),
    .i_rst (rst),
    .i_d   (pll_locked),
    .o_q   (w_locked_s)
  );

  // Sequencer FSM; outputs are loaded with the state so they share its edge.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state <= StResetPll;
      r_cnt   <= '0;
      r_outs  <= state_outs(StResetPll);
      r_retry <= '0;
      r_loss  <= '0;
    end else begin
      unique case (r_state)
        StResetPll: begin
          if (r_cnt == CW'(RST_HOLD_CYCLES - 1)) begin
            r_state <= StWaitLock;
            r_cnt   <= '0;
            r_outs  <= state_outs(StWaitLock);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StWaitLock: begin
          // Lock wins over a timeout landing on the same cycle.
          if (w_locked_s) begin
            r_state <= StStable;
            r_cnt   <= '0;
            r_outs  <= state_outs(StStable);
          end else if (r_cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
            r_retry <= r_retry + 1'b1;
            r_cnt   <= '0;
            if (r_retry == RW'(MAX_RETRIES - 1)) begin
              r_state <= StFail;
              r_outs  <= state_outs(StFail);
            end else begin
              r_state <= StResetPll;
              r_outs  <= state_outs(StResetPll);
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StStable: begin
          // A drop during qualification re-arms the wait without costing a retry.
          if (!w_locked_s) begin
            r_state <= StWaitLock;
            r_cnt   <= '0;
            r_outs  <= state_outs(StWaitLock);
          end else if (r_cnt == CW'(LOCK_STABLE_CYCLES - 1)) begin
            r_state <= StRun;
            r_cnt   <= '0;
            r_outs  <= state_outs(StRun);
            r_retry <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StRun: begin
          // Loss and reinit together count once; reinit alone is not a loss.
          if (!w_locked_s || reinit_req) begin
            r_state <= StResetPll;
            r_cnt   <= '0;
            r_outs  <= state_outs(StResetPll);
            if (!w_locked_s && (r_loss != 8'hFF)) r_loss <= r_loss + 8'd1;
          end
        end
        StFail: begin
          if (reinit_req) begin
            r_state <= StResetPll;
            r_cnt   <= '0;
            r_outs  <= state_outs(StResetPll);
            r_retry <= '0;
          end
        end
        default: begin
          r_state <= StResetPll;
          r_cnt   <= '0;
          r_outs  <= state_outs(StResetPll);
        end
      endcase
    end
  end

  assign pll_rst   = r_outs.pll_rst;
  assign sys_rst   = r_outs.sys_rst;
  assign ready     = r_outs.ready;
  assign fail      = r_outs.fail;
  assign retry_cnt = r_retry;
  assign loss_cnt  = r_loss;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timing parameters.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       reinit_req;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [1:0] retry_cnt;
  logic [7:0] loss_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int n;

  pll_reset_sequencer #(
    .RST_HOLD_CYCLES     (4),
    .LOCK_TIMEOUT_CYCLES (16),
    .LOCK_STABLE_CYCLES  (8),
    .MAX_RETRIES         (2)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .reinit_req (reinit_req),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .fail       (fail),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Count consecutive negedge samples where pll_rst equals v (bounded).
  task automatic run_len(input logic v, output int cnt);
    cnt = 0;
    while (pll_rst === v && cnt < 100) begin
      cnt++;
      @(negedge refclk);
    end
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (ready !== 1'b1 && cnt < 50) begin
      @(negedge refclk);
      cnt++;
    end
  endtask

  // Drop lock while in RUN; returns on the sample where the FSM has reacted.
  task automatic drop_lock(input logic with_reinit);
    pll_locked = 1'b0;
    @(negedge refclk);
    @(negedge refclk);
    chk("loss_sys_rst_pre", sys_rst, 1'b0);
    if (with_reinit) reinit_req = 1'b1;
    @(negedge refclk);
    reinit_req = 1'b0;
  endtask

  task automatic relock();
    int c;
    pll_locked = 1'b1;
    wait_ready(c);
    chk("relock_ready", ready, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b0;
    reinit_req = 1'b0;
    repeat (3) @(negedge refclk);

    // Reset values
    chk("rst_pll_rst", pll_rst, 1'b1);
    chk("rst_sys_rst", sys_rst, 1'b1);
    chk("rst_ready", ready, 1'b0);
    chk("rst_fail", fail, 1'b0);
    chk("rst_retry", retry_cnt, 2'd0);
    chk("rst_loss", loss_cnt, 8'd0);

    // Nominal bring-up
    rst = 1'b0;
    run_len(1'b1, n);
    chk("nom_pll_rst_len", n, 4);
    chk("nom_wait_sys_rst", sys_rst, 1'b1);
    repeat (3) @(negedge refclk);
    pll_locked = 1'b1;
    wait_ready(n);
    chk("nom_ready_latency", n, 11);
    chk("nom_sys_rst", sys_rst, 1'b0);
    chk("nom_pll_rst", pll_rst, 1'b0);
    chk("nom_retry", retry_cnt, 2'd0);

    // Lock loss in RUN
    drop_lock(1'b0);
    chk("loss1_sys_rst", sys_rst, 1'b1);
    chk("loss1_pll_rst", pll_rst, 1'b1);
    chk("loss1_ready", ready, 1'b0);
    chk("loss1_cnt", loss_cnt, 8'd1);
    relock();

    // Lock loss coincident with reinit counts once
    drop_lock(1'b1);
    chk("loss2_pll_rst", pll_rst, 1'b1);
    chk("loss2_cnt", loss_cnt, 8'd2);
    relock();

    // Reinit alone in RUN leaves loss_cnt unchanged
    reinit_req = 1'b1;
    @(negedge refclk);
    reinit_req = 1'b0;
    chk("reinit_pll_rst", pll_rst, 1'b1);
    chk("reinit_ready", ready, 1'b0);
    chk("reinit_loss", loss_cnt, 8'd2);
    wait_ready(n);
    chk("reinit_relock", ready, 1'b1);
    chk("reinit_loss_after", loss_cnt, 8'd2);

    // Timeout path
    rst        = 1'b1;
    pll_locked = 1'b0;
    repeat (2) @(negedge refclk);
    chk("rst2_loss", loss_cnt, 8'd0);
    rst = 1'b0;
    run_len(1'b1, n);
    chk("to_rst_len1", n, 4);
    run_len(1'b0, n);
    chk("to_wait_len1", n, 16);
    chk("to_retry1", retry_cnt, 2'd1);
    run_len(1'b1, n);
    chk("to_rst_len2", n, 4);
    run_len(1'b0, n);
    chk("to_wait_len2", n, 16);
    chk("to_fail", fail, 1'b1);
    chk("to_retry2", retry_cnt, 2'd2);
    chk("to_fail_pll_rst", pll_rst, 1'b1);
    repeat (5) @(negedge refclk);
    chk("fail_held", fail, 1'b1);
    chk("fail_held_pll_rst", pll_rst, 1'b1);
    chk("fail_held_sys_rst", sys_rst, 1'b1);
    chk("fail_held_ready", ready, 1'b0);
    reinit_req = 1'b1;
    @(negedge refclk);
    reinit_req = 1'b0;
    chk("fail_exit_retry", retry_cnt, 2'd0);
    chk("fail_exit_fail", fail, 1'b0);
    chk("fail_exit_pll_rst", pll_rst, 1'b1);

    // Lock on the timeout cycle: one timeout first, then lock on the second
    run_len(1'b1, n);
    chk("sim_rst_len", n, 4);
    run_len(1'b0, n);
    chk("sim_wait_len", n, 16);
    chk("sim_retry1", retry_cnt, 2'd1);
    run_len(1'b1, n);
    chk("sim_rst_len2", n, 4);
    repeat (13) @(negedge refclk);
    pll_locked = 1'b1;
    repeat (3) @(negedge refclk);
    chk("sim_stable_pll_rst", pll_rst, 1'b0);
    chk("sim_stable_retry", retry_cnt, 2'd1);
    chk("sim_stable_fail", fail, 1'b0);
    repeat (7) @(negedge refclk);
    chk("sim_not_ready", ready, 1'b0);
    @(negedge refclk);
    chk("sim_ready", ready, 1'b1);
    chk("sim_run_retry", retry_cnt, 2'd0);

    // Lock glitch in STABLE restarts qualification
    reinit_req = 1'b1;
    @(negedge refclk);
    reinit_req = 1'b0;
    repeat (5) @(negedge refclk);
    chk("gl_stable_pll_rst", pll_rst, 1'b0);
    chk("gl_stable_sys_rst", sys_rst, 1'b1);
    repeat (4) @(negedge refclk);
    pll_locked = 1'b0;
    @(negedge refclk);
    pll_locked = 1'b1;
    repeat (3) @(negedge refclk);
    chk("gl_no_early_ready", ready, 1'b0);
    repeat (7) @(negedge refclk);
    chk("gl_not_ready", ready, 1'b0);
    @(negedge refclk);
    chk("gl_ready", ready, 1'b1);
    chk("gl_loss", loss_cnt, 8'd0);

    // Mid-operation reset during STABLE
    reinit_req = 1'b1;
    @(negedge refclk);
    reinit_req = 1'b0;
    repeat (7) @(negedge refclk);
    rst = 1'b1;
    @(negedge refclk);
    chk("mid_pll_rst", pll_rst, 1'b1);
    chk("mid_sys_rst", sys_rst, 1'b1);
    chk("mid_ready", ready, 1'b0);
    chk("mid_fail", fail, 1'b0);
    chk("mid_retry", retry_cnt, 2'd0);
    rst = 1'b0;
    run_len(1'b1, n);
    chk("mid_pll_rst_len", n, 4);
    wait_ready(n);
    chk("mid_ready_after", ready, 1'b1);

    // Loss counter saturation
    for (int i = 0; i < 300; i++) begin
      drop_lock(1'b0);
      if (i == 0) chk("sat_first", loss_cnt, 8'd1);
      relock();
    end
    chk("sat_loss", loss_cnt, 8'd255);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
